// File: rtl/soc_boot_pkg.sv
// Shared types and constants for the UART boot loader.
package soc_boot_pkg;

  localparam int          LEN_W      = 16;
  localparam int          CSUM_W     = 8;
  localparam logic [7:0]  BOOT_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } boot_state_e;

endpackage

// File: rtl/boot_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words. The first byte of a
// word lands in bits [7:0]. word_valid_o pulses for one cycle after the
// fourth byte, and word_o holds the completed word until the next one.
module boot_word_assembler (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  byte_cnt_q;
  logic [23:0] lanes_q;

  // Byte lane shift and word completion; clr_i drops any partial word.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      byte_cnt_q   <= 2'd0;
      lanes_q      <= 24'd0;
      word_o       <= 32'd0;
      word_valid_o <= 1'b0;
    end else begin
      word_valid_o <= 1'b0;
      if (clr_i) begin
        byte_cnt_q <= 2'd0;
        lanes_q    <= 24'd0;
      end else if (byte_valid_i) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        case (byte_cnt_q)
          2'd0:    lanes_q[7:0]   <= byte_i;
          2'd1:    lanes_q[15:8]  <= byte_i;
          2'd2:    lanes_q[23:16] <= byte_i;
          default: begin
            word_o       <= {byte_i, lanes_q};
            word_valid_o <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/soc_boot_loader.sv
// UART boot loader: parses MAGIC, LEN_LO, LEN_HI, LEN x 4 data bytes
// (plus one checksum byte when BOOT_CHECKSUM_EN is defined) and writes
// the words into instruction RAM, holding the core in reset until done.
//
// state   | meaning
// IDLE    | waiting for MAGIC or boot_skip_i
// LEN_LO  | next byte is the length low byte
// LEN_HI  | next byte is the length high byte; length is range-checked
// DATA    | assembling and writing words
// CSUM    | next byte must cancel the data sum (BOOT_CHECKSUM_EN only)
// DONE    | load complete, core released; terminal
// ERROR   | frame rejected, core held; terminal until reset
module soc_boot_loader
  import soc_boot_pkg::*;
#(
  parameter int         PROGRAM_SIZE = 1024,
  parameter int         ADDR_W       = $clog2(PROGRAM_SIZE),
  parameter logic [7:0] MAGIC        = BOOT_MAGIC
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              boot_skip_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_reset_o,
  output logic              boot_done_o,
  output logic              boot_error_o
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PROGRAM_SIZE);

  boot_state_e       state_q, state_d;
  logic [7:0]        len_lo_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_rx;
  logic [ADDR_W-1:0] word_idx_q;
  logic              core_reset_q;
  logic              word_valid;
  logic [31:0]       word;
  logic              last_word;
  logic              asm_valid;
  logic              asm_clr;

`ifdef BOOT_CHECKSUM_EN
  logic [CSUM_W-1:0] sum_q;
  logic [CSUM_W-1:0] csum_total;
  logic              csum_ok;

  assign csum_total = sum_q + rx_data_i;
  assign csum_ok    = (csum_total == '0);
`endif

  assign len_rx    = {rx_data_i, len_lo_q};
  assign last_word = (LEN_W'(word_idx_q) == (len_q - LEN_W'(1)));
  // The last write cycle may coincide with the checksum byte, so keep it
  // out of the assembler.
  assign asm_valid = rx_valid_i && (state_q == ST_DATA) && !(word_valid && last_word);
  assign asm_clr   = (state_q != ST_DATA);

  boot_word_assembler u_asm (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .clr_i        (asm_clr),
    .byte_valid_i (asm_valid),
    .byte_i       (rx_data_i),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // State register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (boot_skip_i)                             state_d = ST_DONE;
        else if (rx_valid_i && (rx_data_i == MAGIC)) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: if (rx_valid_i) state_d = ST_LEN_HI;
      ST_LEN_HI: begin
        if (rx_valid_i) begin
          if (len_rx > MAX_LEN) state_d = ST_ERROR;
`ifdef BOOT_CHECKSUM_EN
          else if (len_rx == '0) state_d = ST_CSUM;
`else
          else if (len_rx == '0) state_d = ST_DONE;
`endif
          else                   state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_valid && last_word) begin
`ifdef BOOT_CHECKSUM_EN
          if (rx_valid_i) state_d = csum_ok ? ST_DONE : ST_ERROR;
          else            state_d = ST_CSUM;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CSUM: if (rx_valid_i) state_d = csum_ok ? ST_DONE : ST_ERROR;
`endif
      default: state_d = state_q;
    endcase
  end

  // Length capture, word index and core reset release.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      len_lo_q     <= 8'd0;
      len_q        <= '0;
      word_idx_q   <= '0;
      core_reset_q <= 1'b1;
    end else begin
      core_reset_q <= (state_q != ST_DONE);
      if ((state_q == ST_LEN_LO) && rx_valid_i) len_lo_q <= rx_data_i;
      if ((state_q == ST_LEN_HI) && rx_valid_i) begin
        len_q      <= len_rx;
        word_idx_q <= '0;
      end
      if ((state_q == ST_DATA) && word_valid) word_idx_q <= word_idx_q + ADDR_W'(1);
    end
  end

`ifdef BOOT_CHECKSUM_EN
  // Running mod-256 sum of the data bytes.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)                                  sum_q <= '0;
    else if ((state_q == ST_LEN_HI) && rx_valid_i)  sum_q <= '0;
    else if (asm_valid)                             sum_q <= csum_total;
  end
`endif

  assign mem_we_o     = word_valid && (state_q == ST_DATA);
  assign mem_addr_o   = word_idx_q;
  assign mem_wdata_o  = word;
  assign core_reset_o = core_reset_q;
  assign boot_done_o  = (state_q == ST_DONE);
  assign boot_error_o = (state_q == ST_ERROR);

endmodule

// File: tb/tb_soc_boot_loader.sv
// Directed bench for soc_boot_loader; define BOOT_CHECKSUM_EN to cover the
// checksum build.
module tb_soc_boot_loader;

  localparam int ADDR_W = 10;

  logic              clk_i = 1'b0;
  logic              reset_ni = 1'b0;
  logic              boot_skip_i = 1'b0;
  logic              rx_valid_i = 1'b0;
  logic [7:0]        rx_data_i = 8'h00;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              core_reset_o;
  logic              boot_done_o;
  logic              boot_error_o;

  int vectors = 0;
  int miscompares = 0;

  int          wr_count = 0;
  logic [31:0] wr_data [64];
  logic [31:0] wr_addr [64];

  soc_boot_loader dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .boot_skip_i  (boot_skip_i),
    .rx_valid_i   (rx_valid_i),
    .rx_data_i    (rx_data_i),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .core_reset_o (core_reset_o),
    .boot_done_o  (boot_done_o),
    .boot_error_o (boot_error_o)
  );

  always #5 clk_i = ~clk_i;

  // Write log, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (mem_we_o) begin
      wr_addr[wr_count % 64] = 32'(mem_addr_o);
      wr_data[wr_count % 64] = mem_wdata_o;
      wr_count = wr_count + 1;
    end
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    reset_ni = 1'b0;
    wait_cycles(2);
    reset_ni = 1'b1;
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase,
  // so consecutive calls give back-to-back strobes.
  task automatic send_byte(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send_byte(b);
    wait_cycles(2);
  endtask

  task automatic check_idle_outputs(input string tag);
    vectors++;
    if (mem_we_o !== 1'b0) begin miscompares++; $display("FAIL %s mem_we: got %b want 0", tag, mem_we_o); end
    vectors++;
    if (mem_addr_o !== '0) begin miscompares++; $display("FAIL %s mem_addr: got %h want 0", tag, mem_addr_o); end
    vectors++;
    if (mem_wdata_o !== 32'h0) begin miscompares++; $display("FAIL %s mem_wdata: got %h want 0", tag, mem_wdata_o); end
    vectors++;
    if (core_reset_o !== 1'b1) begin miscompares++; $display("FAIL %s core_reset: got %b want 1", tag, core_reset_o); end
    vectors++;
    if (boot_done_o !== 1'b0) begin miscompares++; $display("FAIL %s boot_done: got %b want 0", tag, boot_done_o); end
    vectors++;
    if (boot_error_o !== 1'b0) begin miscompares++; $display("FAIL %s boot_error: got %b want 0", tag, boot_error_o); end
  endtask

  task automatic check_status(input string tag, input logic done, input logic err,
                              input logic core_rst, input int writes, input int base);
    vectors++;
    if (boot_done_o !== done) begin miscompares++; $display("FAIL %s boot_done: got %b want %b", tag, boot_done_o, done); end
    vectors++;
    if (boot_error_o !== err) begin miscompares++; $display("FAIL %s boot_error: got %b want %b", tag, boot_error_o, err); end
    vectors++;
    if (core_reset_o !== core_rst) begin miscompares++; $display("FAIL %s core_reset: got %b want %b", tag, core_reset_o, core_rst); end
    vectors++;
    if ((wr_count - base) !== writes) begin miscompares++; $display("FAIL %s write_count: got %0d want %0d", tag, wr_count - base, writes); end
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] addr, input logic [31:0] data);
    vectors++;
    if (wr_addr[idx % 64] !== addr) begin miscompares++; $display("FAIL %s addr: got %h want %h", tag, wr_addr[idx % 64], addr); end
    vectors++;
    if (wr_data[idx % 64] !== data) begin miscompares++; $display("FAIL %s data: got %h want %h", tag, wr_data[idx % 64], data); end
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    wait_cycles(2);
    check_idle_outputs("reset");
    reset_ni = 1'b1;
    wait_cycles(2);
    check_idle_outputs("post_reset_idle");
  endtask

  task automatic test_skip();
    int base;
    boot_skip_i = 1'b1;
    do_reset();
    base = wr_count;
    wait_cycles(3);
    check_status("skip", 1'b1, 1'b0, 1'b0, 0, base);
    boot_skip_i = 1'b0;
    send_byte(8'hA5);
    wait_cycles(3);
    check_status("skip_ignores_rx", 1'b1, 1'b0, 1'b0, 0, base);
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset();
    base = wr_count;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hB7); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h34);
`endif
    wait_cycles(4);
    check_status("two_word", 1'b1, 1'b0, 1'b0, 2, base);
    check_write("two_word_w0", base, 32'd0, 32'h0000_0013);
    check_write("two_word_w1", base + 1, 32'd1, 32'h0000_02B7);
  endtask

  task automatic test_len_overflow();
    int base;
    do_reset();
    base = wr_count;
    send_gap(8'hA5); send_gap(8'h01); send_gap(8'h04);
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    wait_cycles(3);
    check_status("len_overflow", 1'b0, 1'b1, 1'b1, 0, base);
  endtask

  task automatic test_len_max_boundary();
    int base;
    do_reset();
    base = wr_count;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_cycles(3);
    check_status("len_1024_accepted", 1'b0, 1'b0, 1'b1, 1, base);
    check_write("len_1024_w0", base, 32'd0, 32'h0403_0201);
  endtask

  task automatic test_zero_len();
    int base;
    do_reset();
    base = wr_count;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h00);
`endif
    wait_cycles(3);
    check_status("zero_len", 1'b1, 1'b0, 1'b0, 0, base);
  endtask

  task automatic test_leading_garbage();
    int base;
    do_reset();
    base = wr_count;
    send_gap(8'h00); send_gap(8'hFF); send_gap(8'h5A);
    send_gap(8'hA5); send_gap(8'h01); send_gap(8'h00);
    send_gap(8'hEF); send_gap(8'hBE); send_gap(8'hAD); send_gap(8'hDE);
`ifdef BOOT_CHECKSUM_EN
    send_gap(8'hC8);
`endif
    wait_cycles(3);
    check_status("garbage", 1'b1, 1'b0, 1'b0, 1, base);
    check_write("garbage_w0", base, 32'd0, 32'hDEAD_BEEF);
  endtask

  task automatic test_reset_mid_load();
    int base;
    do_reset();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    reset_ni = 1'b0;
    #1;
    check_idle_outputs("mid_load_reset");
    wait_cycles(2);
    reset_ni = 1'b1;
    base = wr_count;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'hEC);
`endif
    wait_cycles(4);
    check_status("reload", 1'b1, 1'b0, 1'b0, 1, base);
    check_write("reload_w0", base, 32'd0, 32'h1234_5678);
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_bad_checksum();
    int base;
    do_reset();
    base = wr_count;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hB7); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    wait_cycles(2);
    send_byte(8'h00);
    wait_cycles(3);
    check_status("bad_csum", 1'b0, 1'b1, 1'b1, 2, base);
  endtask
`endif

  initial begin
    test_reset();
    test_skip();
    test_back_to_back();
    test_len_overflow();
    test_len_max_boundary();
    test_zero_len();
    test_leading_garbage();
    test_reset_mid_load();
`ifdef BOOT_CHECKSUM_EN
    test_bad_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
